// File: rtl/abc_weighted_acc.sv
// abc_weighted_acc: N_CH-channel A/D sequencer with serial weighted MAC.
// Result leaves through the dav_/rfd handshake with saturation and timeout.
module abc_weighted_acc #(
  parameter int N_CH    = 3,
  parameter int W       = 8,
  parameter int CW      = 4,
  parameter int RW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset_,
  output logic [N_CH-1:0]      soc,
  input  logic [N_CH-1:0]      eoc,
  input  logic [N_CH*W-1:0]    x,
  input  logic [N_CH*CW-1:0]   coef,
  output logic                 dav_,
  input  logic                 rfd,
  output logic [RW-1:0]        result,
  output logic                 ovf,
  output logic                 err
);

  localparam int AW = W + CW + $clog2(N_CH) + 1;
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam int SW = ((AW > RW) ? AW : RW) + 1;
  localparam int PW = W + CW;

  typedef enum logic [2:0] {
    ST_START,
    ST_WAIT,
    ST_MAC,
    ST_OUT,
    ST_ACK
  } state_e;

  state_e              state_q, state_d;
  logic                soc_q, soc_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [N_CH*W-1:0]   xs_q, xs_d;
  logic [N_CH*CW-1:0]  cs_q, cs_d;
  logic                dav_q, dav_d;
  logic [RW-1:0]       res_q, res_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;

  logic [W-1:0]        x_sel;
  logic [CW-1:0]       c_sel;
  logic [PW-1:0]       prod;
  logic [TW-1:0]       cnt_inc;
  logic                tmo;
  logic [SW-1:0]       acc_ext;
  logic [SW-1:0]       rmax;
  logic                sat;

  // Channel operands for the current MAC step come from the captured copy.
  assign x_sel = xs_q[int'(idx_q) * W +: W];
  assign c_sel = cs_q[int'(idx_q) * CW +: CW];
  assign prod  = PW'(x_sel) * PW'(c_sel);

  assign cnt_inc = cnt_q + TW'(1);
  assign tmo     = (TIMEOUT != 0) && (cnt_inc == TW'(TIMEOUT));

  assign acc_ext = SW'(acc_q);
  assign rmax    = (SW'(1) << RW) - SW'(1);
  assign sat     = acc_ext > rmax;

  always_comb begin
    state_d = state_q;
    soc_d   = 1'b0;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    xs_d    = xs_q;
    cs_d    = cs_q;
    dav_d   = dav_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      ST_START: begin
        soc_d = 1'b1;
        if (eoc == '0) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (&eoc) begin
          xs_d    = x;
          cs_d    = coef;
          acc_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = ST_MAC;
        end else if (tmo) begin
          err_d   = 1'b1;
          acc_d   = '0;
          state_d = ST_OUT;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + AW'(prod);
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(N_CH - 1)) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        // dav_ still high means this is the first edge in ST_OUT.
        if (dav_q) begin
          res_d = sat ? '1 : acc_ext[RW-1:0];
          ovf_d = sat;
          dav_d = 1'b0;
          if (!rfd) begin
            state_d = ST_ACK;
          end
        end else if (!rfd) begin
          dav_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        dav_d = 1'b1;
        if (rfd) begin
          state_d = ST_START;
        end
      end
      default: begin
        state_d = ST_START;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_START;
      soc_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      xs_q    <= '0;
      cs_q    <= '0;
      dav_q   <= 1'b1;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      soc_q   <= soc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      xs_q    <= xs_d;
      cs_q    <= cs_d;
      dav_q   <= dav_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign soc    = {N_CH{soc_q}};
  assign dav_   = dav_q;
  assign result = res_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule
